bp_be_drain_sequencer: RTL and testbench

Sequences serializing operations (fence, CSR, interrupt entry, single-step) in the BlackParrot back end. Tracks outstanding memory credits and holds each serializing request until the execution pipe has drained and, for fences, until memory is quiet. Only then does it grant a single dispatch. Sits beside the issue-stage hazard detector, which consumes `busy_o`, `grant_v_o` and the credit flags to gate `chk_dispatch_v_o`.

---
 rtl/bp_be_pkg.sv | 18 +
 rtl/bp_be_mem_credit_counter.sv | 50 +++++
 rtl/bp_be_drain_sequencer.sv | 117 +++++++++++
 tb/tb_bp_be_drain_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the BlackParrot back-end serializing-op drain sequencer.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_drain_fence = 2'd0,
        e_drain_csr   = 2'd1,
        e_drain_irq   = 2'd2,
        e_drain_step  = 2'd3
    } bp_be_drain_type_e;

    typedef enum logic [1:0] {
        e_drain_st_idle        = 2'd0,
        e_drain_st_drain       = 2'd1,
        e_drain_st_grant       = 2'd2,
        e_drain_st_wait_commit = 2'd3
    } bp_be_drain_state_e;

endpackage

// File: rtl/bp_be_mem_credit_counter.sv
// Up/down saturating count of outstanding memory operations with full/empty decode.
// Shared between the drain sequencer and the LSU.
module bp_be_mem_credit_counter #(
    parameter int credits_max_p = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic issue_i,
    input  logic return_i,
    output logic full_o,
    output logic empty_o
);

    localparam int cnt_w_lp = $clog2(credits_max_p + 1);
    localparam logic [cnt_w_lp-1:0] max_lp = cnt_w_lp'(credits_max_p);
    localparam logic [cnt_w_lp-1:0] one_lp = cnt_w_lp'(1);

    logic [cnt_w_lp-1:0] count_q, count_d;

    assign full_o  = (count_q == max_lp);
    assign empty_o = (count_q == '0);

    // Issue and return in the same cycle cancel, even at the limits.
    always_comb begin
        count_d = count_q;
        if (issue_i && !return_i && !full_o) begin
            count_d = count_q + one_lp;
        end else if (return_i && !issue_i && !empty_o) begin
            count_d = count_q - one_lp;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(issue_i && !return_i && full_o));
            assert (!(return_i && !issue_i && empty_o));
        end
    end
`endif

endmodule

// File: rtl/bp_be_drain_sequencer.sv
// Holds serializing ops (fence/csr/irq/step) until the pipe drains, then grants one dispatch.
// Optional drain watchdog with sticky timeout_o when BP_BE_DRAIN_TIMEOUT_EN is defined.
module bp_be_drain_sequencer
    import bp_be_pkg::*;
#(
    parameter int credits_max_p    = 8,
    parameter int timeout_cycles_p = 1024
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              req_v_i,
    input  bp_be_drain_type_e req_type_i,
    output logic              req_ready_o,
    input  logic              instr_in_pipe_i,
    input  logic              mem_issue_i,
    input  logic              mem_return_i,
    output logic              credits_full_o,
    output logic              credits_empty_o,
    output logic              grant_v_o,
    input  logic              commit_i,
    input  logic              flush_i,
    output logic              busy_o
`ifdef BP_BE_DRAIN_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);

    bp_be_drain_state_e state_q, state_d;
    bp_be_drain_type_e  type_q, type_d;
    logic               drain_ok;

    bp_be_mem_credit_counter #(
        .credits_max_p(credits_max_p)
    ) credit_counter (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .issue_i  (mem_issue_i),
        .return_i (mem_return_i),
        .full_o   (credits_full_o),
        .empty_o  (credits_empty_o)
    );

    // Fences must also wait for memory to go quiet; other types only need the pipe empty.
    assign drain_ok = !instr_in_pipe_i && (credits_empty_o || (type_q != e_drain_fence));

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        unique case (state_q)
            e_drain_st_idle: begin
                if (req_v_i) begin
                    state_d = e_drain_st_drain;
                    type_d  = req_type_i;
                end
            end
            e_drain_st_drain: begin
                if (drain_ok) state_d = e_drain_st_grant;
            end
            e_drain_st_grant:       state_d = e_drain_st_wait_commit;
            e_drain_st_wait_commit: begin
                if (commit_i) state_d = e_drain_st_idle;
            end
            default:                state_d = e_drain_st_idle;
        endcase
        if (flush_i) begin
            state_d = e_drain_st_idle;
            type_d  = e_drain_fence;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_drain_st_idle;
            type_q  <= e_drain_fence;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
        end
    end

    assign req_ready_o = (state_q == e_drain_st_idle);
    assign busy_o      = (state_q != e_drain_st_idle);
    assign grant_v_o   = (state_q == e_drain_st_grant);

`ifdef BP_BE_DRAIN_TIMEOUT_EN
    localparam int to_w_lp = $clog2(timeout_cycles_p + 1);
    localparam logic [to_w_lp-1:0] to_max_lp = to_w_lp'(timeout_cycles_p);
    localparam logic [to_w_lp-1:0] to_one_lp = to_w_lp'(1);

    logic [to_w_lp-1:0] to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;

    // The watchdog only flags a stuck drain; it never forces the grant.
    always_comb begin
        to_cnt_d  = '0;
        if (state_q == e_drain_st_drain) begin
            to_cnt_d = (to_cnt_q == to_max_lp) ? to_cnt_q : (to_cnt_q + to_one_lp);
        end
        timeout_d = timeout_q || (to_cnt_q == to_max_lp);
        if (flush_i) timeout_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_bp_be_drain_sequencer.sv
// Directed self-checking bench for bp_be_drain_sequencer (default build; timeout test when
// BP_BE_DRAIN_TIMEOUT_EN is defined).
module tb_bp_be_drain_sequencer;
    import bp_be_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              req_v;
    bp_be_drain_type_e req_type;
    logic              req_ready;
    logic              instr_in_pipe;
    logic              mem_issue;
    logic              mem_return;
    logic              credits_full;
    logic              credits_empty;
    logic              grant_v;
    logic              commit;
    logic              flush;
    logic              busy;
`ifdef BP_BE_DRAIN_TIMEOUT_EN
    logic              timeout;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    bp_be_drain_sequencer #(
        .credits_max_p   (8),
        .timeout_cycles_p(16)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_v_i        (req_v),
        .req_type_i     (req_type),
        .req_ready_o    (req_ready),
        .instr_in_pipe_i(instr_in_pipe),
        .mem_issue_i    (mem_issue),
        .mem_return_i   (mem_return),
        .credits_full_o (credits_full),
        .credits_empty_o(credits_empty),
        .grant_v_o      (grant_v),
        .commit_i       (commit),
        .flush_i        (flush),
        .busy_o         (busy)
`ifdef BP_BE_DRAIN_TIMEOUT_EN
        ,
        .timeout_o      (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_ready actual=%b required=1", req_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy actual=%b required=0", busy); else pass_cnt++;
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL rst_grant actual=%b required=0", grant_v); else pass_cnt++;
        check_cnt++; if (credits_empty !== 1'b1) $display("FAIL rst_empty actual=%b required=1", credits_empty); else pass_cnt++;
        check_cnt++; if (credits_full !== 1'b0) $display("FAIL rst_full actual=%b required=0", credits_full); else pass_cnt++;
`ifdef BP_BE_DRAIN_TIMEOUT_EN
        check_cnt++; if (timeout !== 1'b0) $display("FAIL rst_timeout actual=%b required=0", timeout); else pass_cnt++;
`endif
        step();
        reset_n = 1'b1;
        step();
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL rel_ready actual=%b required=1", req_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL rel_busy actual=%b required=0", busy); else pass_cnt++;
        check_cnt++; if (credits_empty !== 1'b1) $display("FAIL rel_empty actual=%b required=1", credits_empty); else pass_cnt++;
    endtask

    task automatic test_csr_grant();
        req_v = 1'b1; req_type = e_drain_csr; instr_in_pipe = 1'b0;
        step();
        req_v = 1'b0;
        check_cnt++; if (busy !== 1'b1) $display("FAIL csr_drain_busy actual=%b required=1", busy); else pass_cnt++;
        check_cnt++; if (req_ready !== 1'b0) $display("FAIL csr_drain_ready actual=%b required=0", req_ready); else pass_cnt++;
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL csr_early_grant actual=%b required=0", grant_v); else pass_cnt++;
        step();
        check_cnt++; if (grant_v !== 1'b1) $display("FAIL csr_grant actual=%b required=1", grant_v); else pass_cnt++;
        step();
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL csr_grant_pulse actual=%b required=0", grant_v); else pass_cnt++;
        step();
        step();
        check_cnt++; if (busy !== 1'b1) $display("FAIL csr_wait_busy actual=%b required=1", busy); else pass_cnt++;
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL csr_wait_grant actual=%b required=0", grant_v); else pass_cnt++;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL csr_commit_ready actual=%b required=1", req_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL csr_commit_busy actual=%b required=0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        req_v = 1'b1; req_type = e_drain_step;
        step();
        req_v = 1'b0;
        check_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept actual=%b required=1", busy); else pass_cnt++;
        step();
        check_cnt++; if (grant_v !== 1'b1) $display("FAIL b2b_grant actual=%b required=1", grant_v); else pass_cnt++;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check_cnt++; if (busy !== 1'b1) $display("FAIL b2b_commit_in_grant actual=%b required=1", busy); else pass_cnt++;
        commit = 1'b1;
        step();
        commit = 1'b0;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready actual=%b required=1", req_ready); else pass_cnt++;
    endtask

    task automatic test_type_cond();
        req_v = 1'b1; req_type = e_drain_fence; instr_in_pipe = 1'b1;
        step();
        req_v = 1'b0;
        step();
        step();
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL pipe_hold_grant actual=%b required=0", grant_v); else pass_cnt++;
        check_cnt++; if (busy !== 1'b1) $display("FAIL pipe_hold_busy actual=%b required=1", busy); else pass_cnt++;
        instr_in_pipe = 1'b0;
        step();
        check_cnt++; if (grant_v !== 1'b1) $display("FAIL pipe_release_grant actual=%b required=1", grant_v); else pass_cnt++;
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        mem_issue = 1'b1;
        step();
        mem_issue = 1'b0;
        check_cnt++; if (credits_empty !== 1'b0) $display("FAIL one_credit_empty actual=%b required=0", credits_empty); else pass_cnt++;
        req_v = 1'b1; req_type = e_drain_csr;
        step();
        req_v = 1'b0;
        step();
        check_cnt++; if (grant_v !== 1'b1) $display("FAIL csr_ignores_credits actual=%b required=1", grant_v); else pass_cnt++;
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        mem_return = 1'b1;
        step();
        mem_return = 1'b0;
        check_cnt++; if (credits_empty !== 1'b1) $display("FAIL one_credit_back actual=%b required=1", credits_empty); else pass_cnt++;
    endtask

    task automatic test_fence_credits();
        mem_issue = 1'b1;
        for (int i = 0; i < 3; i++) step();
        mem_issue = 1'b0;
        check_cnt++; if (credits_empty !== 1'b0) $display("FAIL fence_cnt3_empty actual=%b required=0", credits_empty); else pass_cnt++;
        req_v = 1'b1; req_type = e_drain_fence; instr_in_pipe = 1'b0;
        step();
        req_v = 1'b0;
        mem_return = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_cnt++; if (grant_v !== 1'b0) $display("FAIL fence_early_grant_%0d actual=%b required=0", i, grant_v); else pass_cnt++;
            check_cnt++;
            if (credits_empty !== (i == 2)) $display("FAIL fence_empty_%0d actual=%b required=%b", i, credits_empty, (i == 2));
            else pass_cnt++;
        end
        mem_return = 1'b0;
        step();
        check_cnt++; if (grant_v !== 1'b1) $display("FAIL fence_grant actual=%b required=1", grant_v); else pass_cnt++;
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic test_credit_saturation();
        mem_issue = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) begin
                check_cnt++; if (credits_full !== 1'b0) $display("FAIL sat_full_at7 actual=%b required=0", credits_full); else pass_cnt++;
            end
        end
        check_cnt++; if (credits_full !== 1'b1) $display("FAIL sat_full_at8 actual=%b required=1", credits_full); else pass_cnt++;
        check_cnt++; if (credits_empty !== 1'b0) $display("FAIL sat_empty_at8 actual=%b required=0", credits_empty); else pass_cnt++;
        mem_return = 1'b1;
        step();
        check_cnt++; if (credits_full !== 1'b1) $display("FAIL sat_both_at_full actual=%b required=1", credits_full); else pass_cnt++;
        mem_issue = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) begin
                check_cnt++; if (credits_full !== 1'b0) $display("FAIL sat_full_at7_down actual=%b required=0", credits_full); else pass_cnt++;
            end
            if (i == 7) begin
                check_cnt++; if (credits_empty !== 1'b0) $display("FAIL sat_empty_at1 actual=%b required=0", credits_empty); else pass_cnt++;
            end
        end
        check_cnt++; if (credits_empty !== 1'b1) $display("FAIL sat_empty_at0 actual=%b required=1", credits_empty); else pass_cnt++;
        mem_issue = 1'b1;
        step();
        mem_issue = 1'b0; mem_return = 1'b0;
        check_cnt++; if (credits_empty !== 1'b1) $display("FAIL sat_both_at_zero actual=%b required=1", credits_empty); else pass_cnt++;
    endtask

    task automatic test_flush();
        mem_issue = 1'b1;
        step();
        step();
        mem_issue = 1'b0;
        req_v = 1'b1; req_type = e_drain_csr; instr_in_pipe = 1'b0;
        step();
        req_v = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_cnt++; if (busy !== 1'b0) $display("FAIL flush_wait_busy actual=%b required=0", busy); else pass_cnt++;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL flush_wait_ready actual=%b required=1", req_ready); else pass_cnt++;
        check_cnt++; if (credits_empty !== 1'b0) $display("FAIL flush_keeps_count actual=%b required=0", credits_empty); else pass_cnt++;
        step();
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL flush_no_grant actual=%b required=0", grant_v); else pass_cnt++;
        mem_return = 1'b1;
        step();
        check_cnt++; if (credits_empty !== 1'b0) $display("FAIL flush_cnt1_empty actual=%b required=0", credits_empty); else pass_cnt++;
        step();
        mem_return = 1'b0;
        check_cnt++; if (credits_empty !== 1'b1) $display("FAIL flush_cnt0_empty actual=%b required=1", credits_empty); else pass_cnt++;
        req_v = 1'b1; req_type = e_drain_irq; instr_in_pipe = 1'b1;
        step();
        req_v = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0; instr_in_pipe = 1'b0;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL flush_drain_ready actual=%b required=1", req_ready); else pass_cnt++;
        step();
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL flush_drain_no_grant actual=%b required=0", grant_v); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        req_v = 1'b1; req_type = e_drain_fence; instr_in_pipe = 1'b1;
        step();
        req_v = 1'b0;
        step();
        check_cnt++; if (busy !== 1'b1) $display("FAIL areset_pre_busy actual=%b required=1", busy); else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        check_cnt++; if (busy !== 1'b0) $display("FAIL areset_busy actual=%b required=0", busy); else pass_cnt++;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL areset_ready actual=%b required=1", req_ready); else pass_cnt++;
        step();
        instr_in_pipe = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_cnt++; if (grant_v !== 1'b0) $display("FAIL areset_no_grant_%0d actual=%b required=0", i, grant_v); else pass_cnt++;
            check_cnt++; if (busy !== 1'b0) $display("FAIL areset_idle_%0d actual=%b required=0", i, busy); else pass_cnt++;
        end
    endtask

`ifdef BP_BE_DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        req_v = 1'b1; req_type = e_drain_irq; instr_in_pipe = 1'b1;
        step();
        req_v = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 16) begin
                check_cnt++; if (timeout !== 1'b0) $display("FAIL timeout_early actual=%b required=0", timeout); else pass_cnt++;
            end
        end
        step();
        check_cnt++; if (timeout !== 1'b1) $display("FAIL timeout_set actual=%b required=1", timeout); else pass_cnt++;
        check_cnt++; if (busy !== 1'b1) $display("FAIL timeout_stays_drain actual=%b required=1", busy); else pass_cnt++;
        check_cnt++; if (grant_v !== 1'b0) $display("FAIL timeout_no_grant actual=%b required=0", grant_v); else pass_cnt++;
        step();
        check_cnt++; if (timeout !== 1'b1) $display("FAIL timeout_sticky actual=%b required=1", timeout); else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0; instr_in_pipe = 1'b0;
        check_cnt++; if (timeout !== 1'b0) $display("FAIL timeout_flush actual=%b required=0", timeout); else pass_cnt++;
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL timeout_flush_ready actual=%b required=1", req_ready); else pass_cnt++;
    endtask
`endif

    initial begin
        reset_n       = 1'b0;
        req_v         = 1'b0;
        req_type      = e_drain_fence;
        instr_in_pipe = 1'b0;
        mem_issue     = 1'b0;
        mem_return    = 1'b0;
        commit        = 1'b0;
        flush         = 1'b0;
        test_reset();
        test_csr_grant();
        test_back_to_back();
        test_type_cond();
        test_fence_credits();
        test_credit_saturation();
        test_flush();
`ifdef BP_BE_DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
